mem_delay_line: RTL
===================

Name: mem_delay_line

Overview:
- Parametrised multi-channel memory-response delay line that sits between the synchronous instruction/data memories and the processor core.
- It generalises the fixed one-cycle registering of inst and mem_dout into NUM_CH independent channels, each with a runtime-selectable latency of 1..MAX_LAT cycles.
- Each channel adds valid tracking, stall (wait-state) freezing, flush and protocol-error detection.
- The testbed and later pipelined cores use it to model slow memories.

Parameters:
- DATA_W, 32, width of each channel's data word
- NUM_CH, 2, number of independent channels (ch0 = inst, ch1 = data by convention)
- MAX_LAT, 4, maximum latency in cycles and number of delay stages per channel (>=1)
- LAT_W, $clog2(MAX_LAT+1), width of one latency field

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous reset, active-high
- lat_cfg  input  NUM_CH*LAT_W  requested latency per channel; field ch at [ch*LAT_W +: LAT_W]
- stall  input  NUM_CH  per-channel freeze
- flush  input  NUM_CH  per-channel discard of all in-flight entries
- in_valid  input  NUM_CH  per-channel word present this cycle
- in_data  input  NUM_CH*DATA_W  per-channel data word
- out_valid  output  NUM_CH  per-channel delayed word valid
- out_data  output  NUM_CH*DATA_W  per-channel delayed data; zero when out_valid=0
- busy  output  NUM_CH  channel has at least one valid entry in its stages
- active_lat  output  NUM_CH*LAT_W  latency currently in force per channel
- err  output  NUM_CH  sticky protocol error per channel

Behaviour:
- Reset (rst=1 at a clock edge): all stage valid and data regs are cleared to 0; out_valid=0, out_data=0, busy=0, err=0; every active_lat field is set to 1. rst overrides all other inputs, including mid-operation. In-flight entries are lost.
- Per channel, the stages are s[0..MAX_LAT-1]. Each stage holds {v, d}.
- Normal cycle (no stall, no flush):
  - s[0] <= {in_valid, in_data}
  - s[k] <= s[k-1] for k >= 1
  - out = s[active_lat-1], gated: out_data = v ? d : 0.
- Latency: a word with in_valid=1 at edge t is presented with out_valid=1 during the cycle following edge t+L-1. That is exactly L cycles later, and L=1 reproduces the plain one-register delay.
- Throughput is one word per cycle per channel, with no bubbles inserted.
- Stall=1 with flush=0: all stages of the channel hold, and out_valid is forced to 0 for that cycle (out_data=0).
  - in_valid=1 during stall drops the word and sets err for that channel.
  - After the stall is released, held entries resume with their remaining latency.
- Flush=1: all stage v bits of the channel are cleared at the edge. in_valid in the same cycle is dropped without error. Flush has priority over stall.
- Latency update: active_lat[ch] <= clamp(lat_cfg[ch]) only at an edge where the channel is drained. Drained means busy=0 and in_valid=0, or flush=1.
  - Otherwise lat_cfg changes are held off until the channel drains, so no entry is ever duplicated or skipped.
  - Clamp rule: 0 is treated as 1; values above MAX_LAT are treated as MAX_LAT.
- busy is the OR of all stage v bits (registered state, no combinational input path).
- err is sticky until rst.
- Channels are fully independent. Simultaneous events on different channels never interact.

Decomposition:
- Shared package mem_delay_pkg: LAT_W function, clamp_lat function, and the channel index constants CH_INST=0 and CH_DATA=1.
- One sub-module, mem_delay_chan: a single-channel stage array plus latency and error logic.
- The top generate-instantiates NUM_CH copies and packs/unpacks the buses.

Test Plan:
- L=1 on ch0: in_valid at cycles 0..3 with data 0x11,0x22,0x33,0x44 -> out_valid at cycles 1..4 with the same data in order; busy falls after cycle 4.
- Set lat_cfg ch1=3 while idle, then a single word 0xDEADBEEF at cycle 10 -> active_lat=3; out_valid only at cycle 13. Also set lat_cfg=0 -> active_lat=1, and lat_cfg=7 with MAX_LAT=4 -> active_lat=4.
- L=2 ch1, words A at cycle 0 and B at cycle 1, stall=1 during cycles 2..3 -> out_valid=0 in cycles 2..3; A appears at cycle 4 and B at cycle 5; err stays 0.
- in_valid=1 during stall on ch0 -> word never emerges; err[0]=1 and stays set; err[1]=0.
- L=4 ch0, three words in flight; flush=1 together with in_valid=1 -> no out_valid afterwards; busy=0 next cycle; err=0. Changing lat_cfg mid-flight with no flush -> active_lat changes only after the channel drains.
- Assert rst for one cycle with both channels busy -> next cycle all outputs are 0 and active_lat=1 on both channels.

Source files
------------

// File: rtl/mem_delay_line_pkg.sv
// Shared definitions for the memory-response delay line: channel indices
// and latency helpers used by both the channel and the top level.
package mem_delay_pkg;

  // Channel 0 carries instruction fetches, channel 1 carries data reads.
  localparam int CH_INST = 0;
  localparam int CH_DATA = 1;

  // Width of a latency field able to hold the values 0..max_lat.
  function automatic int lat_width(input int max_lat);
    return $clog2(max_lat + 1);
  endfunction

  // Map a requested latency onto the legal range 1..max_lat.
  function automatic int clamp_lat(input int req, input int max_lat);
    int res;
    if (req < 1) begin
      res = 1;
    end else if (req > max_lat) begin
      res = max_lat;
    end else begin
      res = req;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_delay_line_if.sv
// Bundle of per-channel request/response buses of the delay line.
// master = the side producing memory words, slave = the delay line itself.
interface mem_delay_line_if #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 2,
  parameter int LAT_W  = 3
) ();

  logic [NUM_CH*LAT_W-1:0]  lat_cfg;
  logic [NUM_CH-1:0]        stall;
  logic [NUM_CH-1:0]        flush;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        busy;
  logic [NUM_CH*LAT_W-1:0]  active_lat;
  logic [NUM_CH-1:0]        err;

  modport master (
    output lat_cfg, stall, flush, in_valid, in_data,
    input  out_valid, out_data, busy, active_lat, err
  );

  modport slave (
    input  lat_cfg, stall, flush, in_valid, in_data,
    output out_valid, out_data, busy, active_lat, err
  );

endinterface

// File: rtl/mem_delay_line_chan.sv
// One delay-line channel: MAX_LAT stages of {valid, data}, a latency that
// is only switched while the channel is empty, and a sticky error flag.
// Only stages 0..active_lat-1 are ever loaded; the rest stay empty, so
// busy reflects exactly the words still owed to the consumer.
module mem_delay_chan
  import mem_delay_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MAX_LAT = 4,
  parameter int LAT_W   = lat_width(MAX_LAT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LAT_W-1:0]  lat_cfg_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              busy_o,
  output logic [LAT_W-1:0]  active_lat_o,
  output logic              err_o
);

  logic [MAX_LAT-1:0]             v_q, v_d;
  logic [MAX_LAT-1:0][DATA_W-1:0] d_q, d_d;
  logic [LAT_W-1:0]               lat_q, lat_d;
  logic                           err_q, err_d;
  logic [LAT_W-1:0]               lat_clamped;
  logic                           drained;
  logic                           sel_v;
  logic [DATA_W-1:0]              sel_d;

  assign lat_clamped = LAT_W'(clamp_lat(int'(lat_cfg_i), MAX_LAT));
  // A flush empties the channel at this edge, so it counts as drained too.
  assign drained     = flush_i | (~(|v_q) & ~in_valid_i);

  // Next-state of stages, latency and error flag.
  always_comb begin
    v_d   = v_q;
    d_d   = d_q;
    lat_d = lat_q;
    err_d = err_q;
    if (flush_i) begin
      v_d = '0;
    end else if (stall_i) begin
      // Stages hold; a word offered while frozen is lost and flagged.
      if (in_valid_i) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else begin
      v_d[0] = in_valid_i;
      d_d[0] = in_data_i;
      for (int k = 1; k < MAX_LAT; k++) begin
        if (k < int'(lat_q)) begin
          v_d[k] = v_q[k-1];
          d_d[k] = d_q[k-1];
        end else begin
          v_d[k] = 1'b0;
        end
      end
    end
    if (drained) begin
      lat_d = lat_clamped;
    end else begin
      lat_d = lat_q;
    end
  end

  // Pick the stage at the active latency as the output tap.
  always_comb begin
    sel_v = 1'b0;
    sel_d = '0;
    for (int k = 0; k < MAX_LAT; k++) begin
      if (int'(lat_q) == k + 1) begin
        sel_v = v_q[k];
        sel_d = d_q[k];
      end else begin
        sel_v = sel_v;
      end
    end
  end

  // State registers with synchronous reset to an empty, latency-1 channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      d_q   <= '0;
      lat_q <= LAT_W'(1);
      err_q <= 1'b0;
    end else begin
      v_q   <= v_d;
      d_q   <= d_d;
      lat_q <= lat_d;
      err_q <= err_d;
    end
  end

  // A stalled cycle presents nothing; the held word re-appears once released.
  assign out_valid_o  = sel_v & ~(stall_i & ~flush_i);
  assign out_data_o   = out_valid_o ? sel_d : '0;
  assign busy_o       = |v_q;
  assign active_lat_o = lat_q;
  assign err_o        = err_q;

endmodule

// File: rtl/mem_delay_line.sv
// Multi-channel memory-response delay line: NUM_CH independent channels,
// each with its own runtime latency, stall, flush and error tracking.
module mem_delay_line
  import mem_delay_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_CH  = 2,
  parameter int MAX_LAT = 4,
  parameter int LAT_W   = lat_width(MAX_LAT)
) (
  input  logic             clk,
  input  logic             rst,
  mem_delay_line_if.slave  bus
);

  logic [NUM_CH-1:0]        out_valid_s;
  logic [NUM_CH*DATA_W-1:0] out_data_s;
  logic [NUM_CH-1:0]        busy_s;
  logic [NUM_CH*LAT_W-1:0]  active_lat_s;
  logic [NUM_CH-1:0]        err_s;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    mem_delay_chan #(
      .DATA_W  (DATA_W),
      .MAX_LAT (MAX_LAT),
      .LAT_W   (LAT_W)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .lat_cfg_i    (bus.lat_cfg[ch*LAT_W +: LAT_W]),
      .stall_i      (bus.stall[ch]),
      .flush_i      (bus.flush[ch]),
      .in_valid_i   (bus.in_valid[ch]),
      .in_data_i    (bus.in_data[ch*DATA_W +: DATA_W]),
      .out_valid_o  (out_valid_s[ch]),
      .out_data_o   (out_data_s[ch*DATA_W +: DATA_W]),
      .busy_o       (busy_s[ch]),
      .active_lat_o (active_lat_s[ch*LAT_W +: LAT_W]),
      .err_o        (err_s[ch])
    );
  end

  assign bus.out_valid  = out_valid_s;
  assign bus.out_data   = out_data_s;
  assign bus.busy       = busy_s;
  assign bus.active_lat = active_lat_s;
  assign bus.err        = err_s;

endmodule
